// File: rtl/mole_game_pkg.sv
// Shared types and constants for the whack-a-mole game engine.
package mole_game_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_GAP  = 3'd1,
    S_UP   = 3'd2,
    S_HIT  = 3'd3,
    S_MISS = 3'd4,
    S_OVER = 3'd5
  } state_t;

  localparam int LEVEL_W = 3;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 in the right-shifting Fibonacci form feed back from bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  // Folds the low three LFSR bits onto 0..n_moles-1. Above four moles a single
  // conditional subtract is enough because the raw value never reaches 2*n_moles.
  function automatic logic [2:0] mole_index(input logic [15:0] lfsr, input int n_moles);
    logic [2:0] raw;
    raw = lfsr[2:0];
    if (2 * n_moles > 8) begin
      if (int'(raw) >= n_moles) return 3'(int'(raw) - n_moles);
      return raw;
    end
    return 3'(int'(raw) % n_moles);
  endfunction

endpackage

// File: rtl/mole_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used to pick which mole pops up.
module mole_lfsr16
  import mole_game_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] q
);

  logic feedback;

  assign feedback = ^(q & LFSR_TAPS);

  // Shift right every cycle, new bit enters at the top; reset reloads the seed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= LFSR_SEED;
    end else begin
      q <= {feedback, q[15:1]};
    end
  end

endmodule

// File: rtl/mole_game_engine.sv
// Whack-a-mole game engine: lights one mole at a time, scores presses,
// speeds up with level, and ends the game after too many misses.
module mole_game_engine
  import mole_game_pkg::*;
#(
  parameter int N_MOLES        = 4,
  parameter int TICK_DIV       = 1000,
  parameter int START_TIMEOUT  = 800,
  parameter int MIN_TIMEOUT    = 200,
  parameter int TIMEOUT_STEP   = 100,
  parameter int HITS_PER_LEVEL = 5,
  parameter int GAP_TICKS      = 50,
  parameter int MAX_MISSES     = 3,
  parameter int SCORE_W        = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [N_MOLES-1:0]   btn,
  output logic [N_MOLES-1:0]   mole_led,
  output logic [SCORE_W-1:0]   score,
  output logic [1:0]           misses,
  output logic [LEVEL_W-1:0]   level,
  output logic                 hit_pulse,
  output logic                 miss_pulse,
  output logic                 game_over
);

  localparam int MAX_TICKS = (START_TIMEOUT > GAP_TICKS) ? START_TIMEOUT : GAP_TICKS;
  localparam int TW        = $clog2(MAX_TICKS + 1);
  localparam int PW        = $clog2(TICK_DIV);
  localparam int HW        = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1;

  state_t          state_q;
  state_t          state_next;
  logic [PW-1:0]   presc_q;
  logic [TW-1:0]   tick_cnt_q;
  logic [TW-1:0]   timeout_q;
  logic [HW-1:0]   lvl_hits_q;
  logic [N_MOLES-1:0] btn_q;
  logic [N_MOLES-1:0] btn_rise;
  logic [2:0]      mole_idx_q;
  logic [2:0]      lfsr_idx;
  logic [2:0]      led_idx;
  logic [15:0]     lfsr_q;
  logic            tick;
  logic            wrong_press;
  logic            right_press;
  logic            up_expired;
  logic            gap_done;
  logic            last_miss;

  mole_lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr_q)
  );

  assign lfsr_idx    = mole_index(lfsr_q, N_MOLES);
  assign btn_rise    = btn & ~btn_q;
  assign wrong_press = |(btn_rise & ~mole_led);
  assign right_press = |(btn_rise & mole_led);
  assign tick        = (presc_q == PW'(TICK_DIV - 1));
  assign gap_done    = tick && (tick_cnt_q == TW'(GAP_TICKS - 1));
  assign up_expired  = tick && (tick_cnt_q == timeout_q - TW'(1));
  assign last_miss   = (32'(misses) + 32'd1) >= 32'(MAX_MISSES);
  assign led_idx     = (state_q == S_GAP) ? lfsr_idx : mole_idx_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // Next-state logic; during UP a wrong press beats a correct one, and any press beats expiry.
  always_comb begin
    state_next = state_q;
    case (state_q)
      S_IDLE: if (start) state_next = S_GAP;
      S_GAP:  if (gap_done) state_next = S_UP;
      S_UP: begin
        if (wrong_press) state_next = S_MISS;
        else if (right_press) state_next = S_HIT;
        else if (up_expired) state_next = S_MISS;
      end
      S_HIT:  state_next = S_GAP;
      S_MISS: state_next = last_miss ? S_OVER : S_GAP;
      S_OVER: if (start) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Event strobes and the game-over flag decode straight from the state.
  always_comb begin
    hit_pulse  = 1'b0;
    miss_pulse = 1'b0;
    game_over  = 1'b0;
    case (state_q)
      S_HIT:  hit_pulse  = 1'b1;
      S_MISS: miss_pulse = 1'b1;
      S_OVER: game_over  = 1'b1;
      default: ;
    endcase
  end

  // Tick prescaler and per-state tick counter, both restarted whenever the state changes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q    <= '0;
      tick_cnt_q <= '0;
    end else if (state_next != state_q) begin
      presc_q    <= '0;
      tick_cnt_q <= '0;
    end else if (tick) begin
      presc_q    <= '0;
      tick_cnt_q <= tick_cnt_q + TW'(1);
    end else begin
      presc_q    <= presc_q + PW'(1);
    end
  end

  // Previous button sample for rising-edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_q <= '0;
    end else begin
      btn_q <= btn;
    end
  end

  // Latch the mole position on GAP exit and drive the LEDs only while UP will be the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mole_idx_q <= '0;
      mole_led   <= '0;
    end else begin
      if (state_q == S_GAP && state_next == S_UP) begin
        mole_idx_q <= lfsr_idx;
      end
      mole_led <= (state_next == S_UP) ? (N_MOLES'(1) << led_idx) : '0;
    end
  end

  // Score, misses, level and the shrinking mole timeout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      score      <= '0;
      misses     <= '0;
      level      <= '0;
      lvl_hits_q <= '0;
      timeout_q  <= TW'(START_TIMEOUT);
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            score      <= '0;
            misses     <= '0;
            level      <= '0;
            lvl_hits_q <= '0;
            timeout_q  <= TW'(START_TIMEOUT);
          end
        end
        S_HIT: begin
          if (score != {SCORE_W{1'b1}}) begin
            score <= score + SCORE_W'(1);
          end
          if (lvl_hits_q == HW'(HITS_PER_LEVEL - 1)) begin
            lvl_hits_q <= '0;
            if (level != LEVEL_MAX) begin
              level <= level + LEVEL_W'(1);
            end
            if (32'(timeout_q) >= 32'(MIN_TIMEOUT + TIMEOUT_STEP)) begin
              timeout_q <= timeout_q - TW'(TIMEOUT_STEP);
            end else begin
              timeout_q <= TW'(MIN_TIMEOUT);
            end
          end else begin
            lvl_hits_q <= lvl_hits_q + HW'(1);
          end
        end
        S_MISS: misses <= misses + 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mole_game_engine.md
MOLE_GAME_ENGINE -- requirements
Module: mole_game_engine

Interface
REQ-001 SHALL take parameter N_MOLES, default 4: number of moles, buttons and LEDs, legal range 2..8.
REQ-002 SHALL take parameter TICK_DIV, default 1000: clk cycles per game tick, at least 2.
REQ-003 SHALL take parameter START_TIMEOUT, default 800: ticks a mole stays up at level 0.
REQ-004 SHALL take parameter MIN_TIMEOUT, default 200, and TIMEOUT_STEP, default 100: timeout floor and per-level decrement.
REQ-005 SHALL take parameter HITS_PER_LEVEL, default 5: hits needed to advance one level.
REQ-006 SHALL take parameter GAP_TICKS, default 50: ticks with all LEDs dark between moles.
REQ-007 SHALL take parameter MAX_MISSES, default 3, and SCORE_W, default 8: misses ending the game and score width.
REQ-008 Port clk, input, 1: sole clock.
REQ-009 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-010 Port start, input, 1: level-sampled start request.
REQ-011 Port btn, input, N_MOLES: player buttons, already synchronised and debounced, active-high.
REQ-012 Port mole_led, output, N_MOLES: one-hot lit mole.
REQ-013 Port score, output, SCORE_W: hit count.
REQ-014 Port misses, output, 2: miss count.
REQ-015 Port level, output, 3: current difficulty level.
REQ-016 Port hit_pulse, output, 1, and miss_pulse, output, 1: single-cycle event strobes.
REQ-017 Port game_over, output, 1: high while in OVER.

Function
REQ-018 States SHALL be IDLE, GAP, UP, HIT, MISS and OVER; the encoding is internal.
REQ-019 Press edges SHALL be detected as btn_rise = btn & ~btn_q, with btn_q registered every cycle.
REQ-020 The tick prescaler SHALL count 0..TICK_DIV-1 and emit a 1-cycle tick at wrap; it restarts at 0 on every state entry.
REQ-021 IDLE: when start=1, the block SHALL clear score, misses and level, load the timeout register with START_TIMEOUT, and go to GAP next cycle.
REQ-022 GAP: mole_led SHALL be 0; after GAP_TICKS ticks the block SHALL latch the mole index and go to UP.
REQ-023 Mole index SHALL come from a free-running 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1); idx = lfsr[2:0] mod N_MOLES, computed by a single conditional subtract of N_MOLES where 2*N_MOLES > 8, else modulo.
REQ-024 UP: mole_led SHALL be one-hot at idx.
REQ-025 UP, btn_rise equal to only the lit bit: next state SHALL be HIT.
REQ-026 UP, btn_rise with any unlit bit, including simultaneously with the lit bit: next state SHALL be MISS (wrong press wins).
REQ-027 UP, timeout register ticks elapsed with no press: next state SHALL be MISS; a press in the same cycle as timeout expiry SHALL take priority.
REQ-028 HIT SHALL last exactly 1 cycle: hit_pulse=1, score +1 saturating at 2^SCORE_W-1, then GAP.
REQ-029 In HIT, every HITS_PER_LEVEL-th hit SHALL increment level (saturating at 7) and reduce timeout by TIMEOUT_STEP, floored at MIN_TIMEOUT.
REQ-030 MISS SHALL last exactly 1 cycle: miss_pulse=1, misses +1; then OVER if misses reaches MAX_MISSES, else GAP.
REQ-031 OVER: game_over=1, mole_led=0, score/misses/level held; start=1 SHALL go to IDLE next cycle.
REQ-032 btn_rise outside UP SHALL be ignored.
REQ-033 mole_led SHALL be registered, with at most one bit set in any cycle.

Reset
REQ-034 On rst_n=0 at a clk edge: state IDLE, all outputs 0, btn_q=0, prescaler 0, LFSR seed reloaded, timeout START_TIMEOUT; this applies from any state, including mid-UP.

Structure
REQ-035 Package mole_game_pkg SHALL hold the state enum, LFSR seed/taps and the level width constant.
REQ-036 The LFSR SHALL be the sub-module mole_lfsr16 (ports clk, rst_n, q[15:0]).
REQ-037 Estimated size is 150-300 RTL lines.

Verification
Directed scenarios use N_MOLES=4, TICK_DIV=4, START_TIMEOUT=8, GAP_TICKS=2, HITS_PER_LEVEL=2, TIMEOUT_STEP=2, MIN_TIMEOUT=4, MAX_MISSES=3.
REQ-038 Start then correct press during UP -> hit_pulse 1 cycle after edge, score=1, LEDs dark for 8 cycles, new mole.
REQ-039 No press -> miss_pulse 32 cycles after UP entry, misses=1; three timeouts -> game_over=1, score held.
REQ-040 Lit plus unlit button pressed in the same cycle -> miss_pulse, score unchanged.
REQ-041 Six hits -> level=3; timeout 8->6->4->4, with UP lasting 16 cycles at the floor.
REQ-042 rst_n low for 1 cycle mid-UP -> next cycle state IDLE, mole_led=0, score=0; start restores identical LFSR sequence.
REQ-043 Score at 2^SCORE_W-1 plus a further hit -> holds at 2^SCORE_W-1, hit_pulse still asserted.
